demorgan_bist: RTL and testbench

- Self-checking stimulus/response engine for the De Morgan gate block: drives every (a, b) input combination into the block and checks both returned outputs against expected values.
- Expected values: notd = ~(a & b) and c = ~a | ~b, bitwise.
- Replaces open-loop stimulus and print monitoring with an in-fabric pass/fail verdict and an error count.
- Sits beside the gate block: a_o/b_o go to its inputs; its notd/c come back on notd_i/c_i.

---
 rtl/demorgan_bist_if.sv | 24 ++
 rtl/demorgan_bist.sv | 96 +++++++++
 tb/tb_demorgan_bist.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/demorgan_bist_if.sv
// demorgan_bist_if: stimulus/response and verdict bundle between the De Morgan BIST engine and its host
interface demorgan_bist_if #(
  parameter int WIDTH = 1,
  parameter int ERR_CNT_W = 8
);
  logic start;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] notd_i;
  logic [WIDTH-1:0] c_i;
  logic busy;
  logic done;
  logic pass;
  logic [ERR_CNT_W-1:0] err_count;
  logic [2*WIDTH-1:0] first_err_vec;
  modport master (
    output start, notd_i, c_i,
    input a_o, b_o, busy, done, pass, err_count, first_err_vec
  );
  modport slave (
    input start, notd_i, c_i,
    output a_o, b_o, busy, done, pass, err_count, first_err_vec
  );
endinterface

// File: rtl/demorgan_bist.sv
// demorgan_bist: sweeps every (a,b) pair through a De Morgan gate block and checks notd/c against ~(a&b) and ~a|~b.
// Define DEMORGAN_BIST_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module demorgan_bist #(
  parameter int WIDTH = 1,
  parameter int SETTLE = 4,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  demorgan_bist_if.slave bus
);
  localparam int VW = 2 * WIDTH;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] vec_q, vec_d, first_q, first_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [ERR_CNT_W-1:0] err_q, err_d, err_inc;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [WIDTH-1:0] a, b;
  logic mis, stop;
  assign a = vec_q[VW-1:WIDTH];
  assign b = vec_q[WIDTH-1:0];
  assign mis = (bus.notd_i != ~(a & b)) || (bus.c_i != (~a | ~b));
  assign err_inc = &err_q ? err_q : err_q + 1'b1;
`ifdef DEMORGAN_BIST_STOP_ON_ERR_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    settle_d = settle_q;
    err_d = err_q;
    first_d = first_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && bus.start) begin
      state_d = ST_SETTLE;
      vec_d = '0;
      settle_d = '0;
      err_d = '0;
      first_d = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (state_q == ST_SETTLE) begin
      settle_d = settle_q == SW'(SETTLE - 1) ? '0 : settle_q + 1'b1;
      state_d = settle_q == SW'(SETTLE - 1) ? ST_CHECK : ST_SETTLE;
    end else if (state_q == ST_CHECK) begin
      err_d = mis ? err_inc : err_q;
      first_d = mis && err_q == '0 ? vec_q : first_q;
      // the terminal vector exits instead of wrapping; a_o/b_o keep the last vector checked
      if (&vec_q || stop) begin
        state_d = ST_DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = err_d == '0;
      end else begin
        state_d = ST_SETTLE;
        vec_d = vec_q + 1'b1;
        settle_d = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q <= '0;
      settle_q <= '0;
      err_q <= '0;
      first_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      settle_q <= settle_d;
      err_q <= err_d;
      first_q <= first_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign bus.a_o = a;
  assign bus.b_o = b;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.err_count = err_q;
  assign bus.first_err_vec = first_q;
endmodule

// File: tb/tb_demorgan_bist.sv
// tb_demorgan_bist: directed checks of the De Morgan BIST engine against healthy and faulty gate models
module tb_demorgan_bist;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int fm1 = 0;
  int fm2 = 0;
  always #5 clk = ~clk;
  demorgan_bist_if #(.WIDTH(1), .ERR_CNT_W(8)) b1();
  demorgan_bist_if #(.WIDTH(2), .ERR_CNT_W(2)) b2();
  demorgan_bist #(.WIDTH(1), .SETTLE(4), .ERR_CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  demorgan_bist #(.WIDTH(2), .SETTLE(4), .ERR_CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  // gate block models: fm 0 healthy, 1 c stuck at 0, 2 notd forced to 1 when a=b=1
  assign b1.notd_i = (fm1 == 2 && b1.a_o == 1'b1 && b1.b_o == 1'b1) ? 1'b1 : ~(b1.a_o & b1.b_o);
  assign b1.c_i = fm1 == 1 ? 1'b0 : ~b1.a_o | ~b1.b_o;
  assign b2.notd_i = ~(b2.a_o & b2.b_o);
  assign b2.c_i = fm2 == 1 ? 2'b00 : ~b2.a_o | ~b2.b_o;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go1();
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] g1;
    logic [19:0] g2;
    rst = 1'b1;
    #1;
    g1 = {b1.a_o, b1.b_o, b1.busy, b1.done, b1.pass, b1.err_count, b1.first_err_vec};
    tests++;
    if (g1 !== 15'd0) begin fails++; $display("FAIL reset_u1: got %h expected 0", g1); end
    g2 = {b2.a_o, b2.b_o, b2.busy, b2.done, b2.pass, b2.err_count, b2.first_err_vec};
    tests++;
    if (g2 !== 20'd0) begin fails++; $display("FAIL reset_u2: got %h expected 0", g2); end
    tick(2);
    rst = 1'b0;
    tick(3);
    g1 = {b1.a_o, b1.b_o, b1.busy, b1.done, b1.pass, b1.err_count, b1.first_err_vec};
    tests++;
    if (g1 !== 15'd0) begin fails++; $display("FAIL idle_hold: got %h expected 0", g1); end
  endtask

  task automatic test_sweep();
    logic [3:0] got, exp;
    fm1 = 0;
    go1();
    for (int c = 0; c < 20; c++) begin
      exp = {2'b10, 2'(c / 5)};
      got = {b1.busy, b1.done, b1.a_o, b1.b_o};
      tests++;
      if (got !== exp) begin fails++; $display("FAIL sweep_cycle%0d busy/done/a/b: got %b expected %b", c, got, exp); end
      tick();
    end
    got = {b1.busy, b1.done, b1.pass, |b1.err_count};
    tests++;
    if (got !== 4'b0110) begin fails++; $display("FAIL sweep_verdict busy/done/pass/err: got %b expected 0110", got); end
    tick(3);
    got = {b1.done, b1.pass, b1.a_o, b1.b_o};
    tests++;
    if (got !== 4'b1111) begin fails++; $display("FAIL done_hold done/pass/a/b: got %b expected 1111", got); end
  endtask

  task automatic test_c_stuck();
    fm1 = 1;
    go1();
    tick(20);
    tests++;
    if ({b1.busy, b1.done, b1.pass} !== 3'b010) begin fails++; $display("FAIL cstuck_flags: got %b expected 010", {b1.busy, b1.done, b1.pass}); end
    tests++;
    if (b1.err_count !== 8'd3) begin fails++; $display("FAIL cstuck_err: got %0d expected 3", b1.err_count); end
    tests++;
    if (b1.first_err_vec !== 2'd0) begin fails++; $display("FAIL cstuck_first: got %0d expected 0", b1.first_err_vec); end
  endtask

  task automatic test_notd_11();
    fm1 = 2;
    go1();
    tick(19);
    tests++;
    if (b1.done !== 1'b0) begin fails++; $display("FAIL notd_early_done: got %b expected 0", b1.done); end
    tick();
    tests++;
    if ({b1.done, b1.pass} !== 2'b10) begin fails++; $display("FAIL notd_flags: got %b expected 10", {b1.done, b1.pass}); end
    tests++;
    if (b1.err_count !== 8'd1) begin fails++; $display("FAIL notd_err: got %0d expected 1", b1.err_count); end
    tests++;
    if (b1.first_err_vec !== 2'd3) begin fails++; $display("FAIL notd_first: got %0d expected 3", b1.first_err_vec); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] g1;
    fm1 = 0;
    go1();
    tick(7);
    tests++;
    if ({b1.busy, b1.a_o, b1.b_o} !== 3'b101) begin fails++; $display("FAIL mid_vec busy/a/b: got %b expected 101", {b1.busy, b1.a_o, b1.b_o}); end
    rst = 1'b1;
    #1;
    g1 = {b1.a_o, b1.b_o, b1.busy, b1.done, b1.pass, b1.err_count, b1.first_err_vec};
    tests++;
    if (g1 !== 15'd0) begin fails++; $display("FAIL async_reset: got %h expected 0", g1); end
    tick();
    rst = 1'b0;
    tick(2);
    tests++;
    if ({b1.busy, b1.done} !== 2'b00) begin fails++; $display("FAIL post_reset_idle busy/done: got %b expected 00", {b1.busy, b1.done}); end
    go1();
    tick(19);
    tests++;
    if (b1.done !== 1'b0) begin fails++; $display("FAIL rerun_early_done: got %b expected 0", b1.done); end
    tick();
    tests++;
    if ({b1.done, b1.pass, b1.busy} !== 3'b110) begin fails++; $display("FAIL rerun_verdict done/pass/busy: got %b expected 110", {b1.done, b1.pass, b1.busy}); end
  endtask

  task automatic test_start_busy();
    fm1 = 1;
    go1();
    tick(5);
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    tests++;
    if ({b1.busy, b1.a_o, b1.b_o} !== 3'b101) begin fails++; $display("FAIL busy_start_vec busy/a/b: got %b expected 101", {b1.busy, b1.a_o, b1.b_o}); end
    tick(13);
    tests++;
    if (b1.done !== 1'b0) begin fails++; $display("FAIL busy_start_early: got %b expected 0", b1.done); end
    tick();
    tests++;
    if ({b1.done, b1.err_count} !== {1'b1, 8'd3}) begin fails++; $display("FAIL busy_start_end done/err: got %b/%0d expected 1/3", b1.done, b1.err_count); end
    fm1 = 0;
    go1();
    tests++;
    if ({b1.busy, b1.done, b1.pass, b1.err_count} !== 11'b100_0000_0000) begin fails++; $display("FAIL restart_clear busy/done/pass/err: got %b/%b/%b/%0d expected 1/0/0/0", b1.busy, b1.done, b1.pass, b1.err_count); end
    tick(20);
    tests++;
    if ({b1.done, b1.pass, b1.err_count} !== 10'b11_0000_0000) begin fails++; $display("FAIL restart_verdict done/pass/err: got %b/%b/%0d expected 1/1/0", b1.done, b1.pass, b1.err_count); end
  endtask

  task automatic test_w2_saturate();
    fm2 = 1;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
`ifdef DEMORGAN_BIST_STOP_ON_ERR_EN
    tick(4);
    tests++;
    if (b2.done !== 1'b0) begin fails++; $display("FAIL w2_stop_early: got %b expected 0", b2.done); end
    tick();
    tests++;
    if ({b2.done, b2.pass, b2.busy, b2.err_count} !== 5'b10001) begin fails++; $display("FAIL w2_stop done/pass/busy/err: got %b expected 10001", {b2.done, b2.pass, b2.busy, b2.err_count}); end
    tick(3);
    tests++;
    if ({b2.first_err_vec, b2.a_o, b2.b_o} !== 8'd0) begin fails++; $display("FAIL w2_stop_hold first/a/b: got %h expected 0", {b2.first_err_vec, b2.a_o, b2.b_o}); end
`else
    tick(10);
    tests++;
    if ({b2.a_o, b2.b_o, b2.err_count} !== 6'b0010_10) begin fails++; $display("FAIL w2_mid a/b/err: got %b expected 001010", {b2.a_o, b2.b_o, b2.err_count}); end
    tick(10);
    tests++;
    if ({b2.busy, b2.err_count} !== 3'b111) begin fails++; $display("FAIL w2_saturated busy/err: got %b expected 111", {b2.busy, b2.err_count}); end
    tick(59);
    tests++;
    if (b2.done !== 1'b0) begin fails++; $display("FAIL w2_early_done: got %b expected 0", b2.done); end
    tick();
    tests++;
    if ({b2.done, b2.pass, b2.err_count, b2.first_err_vec} !== 8'b10_11_0000) begin fails++; $display("FAIL w2_verdict done/pass/err/first: got %b expected 10110000", {b2.done, b2.pass, b2.err_count, b2.first_err_vec}); end
`endif
  endtask

  initial begin
    b1.start = 1'b0;
    b2.start = 1'b0;
    test_reset();
    test_sweep();
    test_c_stuck();
    test_notd_11();
    test_reset_mid();
    test_start_busy();
    test_w2_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
